// File: rtl/pattern_pkg.sv
// Shared types and constants for the JESD loopback pattern burst controller
// and its loopback checker.
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_FIN
  } state_t;

  localparam logic [3:0] PATTERN_TAIL    = 4'b1010;
  localparam int         PATTERN_CNT_W   = 10;
  localparam int         PATTERN_CNT_LSB = 4;

endpackage

// File: rtl/pattern_loop_checker.sv
// Loopback checker: validates returned pattern words {count, 4'b1010} and keeps
// a saturating error count plus a sticky error flag.
module pattern_loop_checker
  import pattern_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLEAR,
  input  logic [31:0]      RX_DATA,
  input  logic             RX_VALID,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             ERR_FLAG
);

  localparam int UPPER_LSB = PATTERN_CNT_LSB + PATTERN_CNT_W;

  logic [PATTERN_CNT_W-1:0] exp_cnt;
  logic [PATTERN_CNT_W-1:0] rx_cnt;
  logic                     seeded;
  logic                     word_err;

  assign rx_cnt = RX_DATA[PATTERN_CNT_LSB +: PATTERN_CNT_W];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    word_err = 1'b0;
    if (RX_DATA[PATTERN_CNT_LSB-1:0] != PATTERN_TAIL) word_err = 1'b1;
    if (RX_DATA[31:UPPER_LSB] != '0)                  word_err = 1'b1;
    if (seeded && (rx_cnt != exp_cnt))                word_err = 1'b1;
  end

  // A restart clears everything and discards a word arriving in the same cycle.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      exp_cnt  <= '0;
      seeded   <= 1'b0;
      ERR_CNT  <= '0;
      ERR_FLAG <= 1'b0;
    end else if (CLEAR) begin
      exp_cnt  <= '0;
      seeded   <= 1'b0;
      ERR_CNT  <= '0;
      ERR_FLAG <= 1'b0;
    end else if (RX_VALID) begin
      exp_cnt <= rx_cnt + PATTERN_CNT_W'(1);
      seeded  <= 1'b1;
      if (word_err) begin
        ERR_FLAG <= 1'b1;
        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_burst_ctrl.sv
// Burst sequencer for the test-pattern generator: NUM_BURSTS bursts of BURST_LEN
// unmuted cycles separated by GAP_LEN muted cycles, plus the RX loopback checker.
module pattern_burst_ctrl
  import pattern_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int NB_W  = 8,
  parameter int ERR_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [LEN_W-1:0] BURST_LEN,
  input  logic [LEN_W-1:0] GAP_LEN,
  input  logic [NB_W-1:0]  NUM_BURSTS,
  output logic             GEN_TRIG,
  output logic             BUSY,
  output logic             DONE,
  output logic [NB_W-1:0]  BURST_IDX,
  input  logic [31:0]      RX_DATA,
  input  logic             RX_VALID,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             ERR_FLAG
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, gap_q, cnt_q, cnt_d;
  logic [NB_W-1:0]  nb_q, idx_d;
  logic             start_ok;
  logic             trig_d, busy_d, done_d;

  assign start_ok = START && (state_q == ST_IDLE);

  // State, counters, latched config and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      nb_q      <= '0;
      BURST_IDX <= '0;
      GEN_TRIG  <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      BURST_IDX <= idx_d;
      GEN_TRIG  <= trig_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      if (start_ok) begin
        len_q <= BURST_LEN;
        gap_q <= GAP_LEN;
        nb_q  <= NUM_BURSTS;
      end
    end
  end

  // cnt_q holds the cycles remaining in the current RUN/GAP phase minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = BURST_IDX;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          idx_d = '0;
          if ((BURST_LEN == '0) || (NUM_BURSTS == '0)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
            cnt_d   = BURST_LEN - LEN_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          state_d = ST_FIN;
        end else if (cnt_q == '0) begin
          if (BURST_IDX == nb_q - NB_W'(1)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_GAP;
            cnt_d   = (gap_q == '0) ? '0 : gap_q - LEN_W'(1);
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (ABORT) begin
          state_d = ST_FIN;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = len_q - LEN_W'(1);
          idx_d   = BURST_IDX + NB_W'(1);
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered above.
  always_comb begin
    trig_d = (state_d != ST_RUN);
    busy_d = (state_d == ST_RUN) || (state_d == ST_GAP);
    done_d = (state_d == ST_FIN);
  end

  pattern_loop_checker #(
    .ERR_W (ERR_W)
  ) u_checker (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLEAR    (start_ok),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .ERR_CNT  (ERR_CNT),
    .ERR_FLAG (ERR_FLAG)
  );

endmodule

// File: tb/tb_pattern_burst_ctrl.sv
// Self-checking bench for pattern_burst_ctrl: table vectors, randomized sequences
// against a waveform model, checker scenarios and a narrow-counter saturation copy.
module tb_pattern_burst_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, START, ABORT, RX_VALID;
  logic [15:0] BURST_LEN, GAP_LEN;
  logic [7:0]  NUM_BURSTS;
  logic [31:0] RX_DATA;
  logic        GEN_TRIG, BUSY, DONE, ERR_FLAG;
  logic [7:0]  BURST_IDX;
  logic [15:0] ERR_CNT;
  logic        s_trig, s_busy, s_done, s_err_flag;
  logic [7:0]  s_idx;
  logic [3:0]  s_err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  pattern_burst_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .BURST_LEN(BURST_LEN), .GAP_LEN(GAP_LEN), .NUM_BURSTS(NUM_BURSTS),
    .GEN_TRIG(GEN_TRIG), .BUSY(BUSY), .DONE(DONE), .BURST_IDX(BURST_IDX),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .ERR_CNT(ERR_CNT), .ERR_FLAG(ERR_FLAG)
  );

  pattern_burst_ctrl #(.ERR_W(4)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .BURST_LEN(BURST_LEN), .GAP_LEN(GAP_LEN), .NUM_BURSTS(NUM_BURSTS),
    .GEN_TRIG(s_trig), .BUSY(s_busy), .DONE(s_done), .BURST_IDX(s_idx),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .ERR_CNT(s_err_cnt), .ERR_FLAG(s_err_flag)
  );

  typedef struct {
    int len; int gap; int nb; int abort_at;
    int exp_low; int exp_busy; int exp_done_at; int exp_idx;
  } seq_vec_t;

  typedef struct {
    logic [31:0] data; logic valid; int exp_cnt; logic exp_flag;
  } chk_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Single START pulse with the given config, sampled one cycle later.
  task automatic pulse_start(input int len, input int gap, input int nb);
    BURST_LEN  = 16'(len);
    GAP_LEN    = 16'(gap);
    NUM_BURSTS = 8'(nb);
    START      = 1'b1;
    tick();
    START      = 1'b0;
  endtask

  function automatic logic [10:0] pk(input bit t, input bit b, input bit d, input int idx);
    return {t, b, d, 8'(idx)};
  endfunction

  seq_vec_t seq_tab[8];
  chk_vec_t chk_tab[7];

  initial begin
    int low, busy, done_at, done_n, idx_at_done;
    logic [10:0] q[$];
    logic [10:0] q2[$];
    int len, gap, nb, ab;
    int exp_m, errs_m, fld;
    bit seeded_m, e;
    logic [31:0] w, d1, d2;
    logic v1, v2, gv;
    logic [9:0] gcnt;

    seq_tab[0] = '{8, 4, 3, -1, 24, 32, 32, 2};
    seq_tab[1] = '{0, 4, 3, -1,  0,  0,  0, 0};
    seq_tab[2] = '{5, 2, 0, -1,  0,  0,  0, 0};
    seq_tab[3] = '{3, 0, 2, -1,  6,  7,  7, 1};
    seq_tab[4] = '{4, 1, 1, -1,  4,  4,  4, 0};
    seq_tab[5] = '{2, 3, 4, -1,  8, 17, 17, 3};
    seq_tab[6] = '{8, 4, 3, 14, 11, 15, 15, 1};
    seq_tab[7] = '{5, 3, 2,  6,  5,  7,  7, 0};

    chk_tab[0] = '{32'h0000_0000, 1'b0, 0, 1'b0};
    chk_tab[1] = '{32'h0000_0000, 1'b1, 1, 1'b1};
    chk_tab[2] = '{32'h0000_0AB0, 1'b1, 2, 1'b1};
    chk_tab[3] = '{32'h0004_0011, 1'b1, 3, 1'b1};
    chk_tab[4] = '{32'h0000_002A, 1'b1, 3, 1'b1};
    chk_tab[5] = '{32'h0000_003A, 1'b1, 3, 1'b1};
    chk_tab[6] = '{32'h0000_005A, 1'b1, 4, 1'b1};

    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; RX_VALID = 1'b0; RX_DATA = '0;
    BURST_LEN = '0; GAP_LEN = '0; NUM_BURSTS = '0;
    tick(); tick();
    check("reset_outputs", {GEN_TRIG, BUSY, DONE, BURST_IDX, ERR_FLAG}, {1'b1, 1'b0, 1'b0, 8'd0, 1'b0});
    check("reset_err_cnt", ERR_CNT, 0);
    RST_N = 1'b1;
    tick();

    // Table-driven burst sequences
    foreach (seq_tab[i]) begin
      pulse_start(seq_tab[i].len, seq_tab[i].gap, seq_tab[i].nb);
      low = 0; busy = 0; done_at = -1; done_n = 0; idx_at_done = -1;
      for (int c = 0; c < 60; c++) begin
        if (!GEN_TRIG) low++;
        if (BUSY) busy++;
        if (DONE) begin
          done_n++;
          if (done_at < 0) begin
            done_at = c;
            idx_at_done = int'(BURST_IDX);
          end
        end
        ABORT = (c == seq_tab[i].abort_at);
        tick();
      end
      ABORT = 1'b0;
      check($sformatf("tab%0d_low", i), low, seq_tab[i].exp_low);
      check($sformatf("tab%0d_busy", i), busy, seq_tab[i].exp_busy);
      check($sformatf("tab%0d_done_at", i), done_at, seq_tab[i].exp_done_at);
      check($sformatf("tab%0d_done_n", i), done_n, 1);
      check($sformatf("tab%0d_idx", i), idx_at_done, seq_tab[i].exp_idx);
      check($sformatf("tab%0d_idle", i), {GEN_TRIG, BUSY}, 2'b10);
    end

    // Randomized sequences against an expected-waveform model
    for (int it = 0; it < 30; it++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      gap = int'($urandom_range(0, 4));
      nb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 24)) : -1;
      q.delete();
      if (len == 0 || nb == 0) q.push_back(pk(1, 0, 1, 0));
      else begin
        for (int b = 0; b < nb; b++) begin
          for (int k = 0; k < len; k++) q.push_back(pk(0, 1, 0, b));
          if (b < nb - 1)
            for (int k = 0; k < ((gap == 0) ? 1 : gap); k++) q.push_back(pk(1, 1, 0, b));
        end
        q.push_back(pk(1, 0, 1, nb - 1));
      end
      if (ab >= 0 && ab < q.size() && q[ab][9]) begin
        q2.delete();
        for (int k = 0; k <= ab; k++) q2.push_back(q[k]);
        q2.push_back(pk(1, 0, 1, int'(q[ab][7:0])));
        q = q2;
      end
      q.push_back({3'b100, q[q.size()-1][7:0]});
      q.push_back({3'b100, q[q.size()-1][7:0]});

      pulse_start(len, gap, nb);
      for (int c = 0; c < q.size(); c++) begin
        check("rand_seq", {GEN_TRIG, BUSY, DONE, BURST_IDX}, q[c]);
        START      = q[c][9] && ($urandom_range(0, 3) == 0);
        ABORT      = (c == ab) || (!q[c][9] && ($urandom_range(0, 3) == 0));
        BURST_LEN  = 16'($urandom_range(0, 6));
        GAP_LEN    = 16'($urandom_range(0, 4));
        NUM_BURSTS = 8'($urandom_range(0, 4));
        tick();
      end
      START = 1'b0;
      ABORT = 1'b0;
    end

    // START and ABORT together in IDLE: START wins
    BURST_LEN = 16'd3; GAP_LEN = 16'd1; NUM_BURSTS = 8'd1;
    START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    check("start_abort_run", {GEN_TRIG, BUSY}, 2'b01);
    tick(); tick(); tick();
    check("start_abort_done", {GEN_TRIG, BUSY, DONE}, 3'b101);
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abort_idle", {GEN_TRIG, BUSY, DONE}, 3'b100);

    // Clean loopback through a 2-cycle generator model, across the count wrap
    gcnt = 10'h3FC; d1 = '0; d2 = '0; v1 = 1'b0; v2 = 1'b0;
    pulse_start(4, 2, 3);
    for (int c = 0; c < 40; c++) begin
      gv = !GEN_TRIG;
      w  = gv ? {18'd0, gcnt, 4'b1010} : 32'd0;
      if (gv) gcnt = gcnt + 10'd1;
      RX_DATA = d2; RX_VALID = v2;
      d2 = d1; v2 = v1; d1 = w; v1 = gv;
      tick();
    end
    RX_VALID = 1'b0;
    check("clean_err_cnt", ERR_CNT, 0);
    check("clean_err_flag", ERR_FLAG, 1'b0);
    check("clean_gen_count", gcnt, 10'h008);

    // Checker error vectors
    pulse_start(0, 0, 0);
    foreach (chk_tab[i]) begin
      RX_DATA = chk_tab[i].data; RX_VALID = chk_tab[i].valid;
      tick();
      check($sformatf("chk%0d_cnt", i), ERR_CNT, chk_tab[i].exp_cnt);
      check($sformatf("chk%0d_flag", i), ERR_FLAG, chk_tab[i].exp_flag);
    end

    // Restart with an RX error in the same cycle: clear wins, seed cleared
    RX_DATA = 32'h0; RX_VALID = 1'b1;
    pulse_start(0, 0, 0);
    check("restart_cnt", ERR_CNT, 0);
    check("restart_flag", ERR_FLAG, 1'b0);
    RX_DATA = 32'h0000_123A;
    tick();
    check("restart_first_word", ERR_CNT, 0);
    RX_DATA = 32'h0000_124A;
    tick();
    check("restart_next_word", ERR_CNT, 0);
    RX_DATA = 32'h0000_126A;
    tick();
    check("restart_skip_word", ERR_CNT, 1);
    RX_VALID = 1'b0;

    // Randomized checker stream against a counting model
    pulse_start(0, 0, 0);
    exp_m = 0; errs_m = 0; seeded_m = 1'b0;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          w = {18'd0, 10'(seeded_m ? exp_m : int'($urandom_range(1000, 1023))), 4'hA};
        6: w = {18'd0, 10'(exp_m), 4'($urandom_range(0, 9))};
        7: w = {18'($urandom_range(1, 255)), 10'(exp_m), 4'hA};
        8: w = {18'd0, 10'(exp_m + int'($urandom_range(1, 5))), 4'hA};
        default: w = $urandom;
      endcase
      RX_DATA = w;
      RX_VALID = ($urandom_range(0, 7) != 0);
      if (RX_VALID) begin
        fld = int'(w >> 4) % 1024;
        e = (w % 16 != 10) || (w >= 32'h4000) || (seeded_m && fld != exp_m);
        if (e && errs_m < 65535) errs_m++;
        exp_m = (fld + 1) % 1024;
        seeded_m = 1'b1;
      end
      tick();
      check("rand_chk_cnt", ERR_CNT, errs_m);
      check("rand_chk_flag", ERR_FLAG, errs_m > 0);
    end
    RX_VALID = 1'b0;

    // Saturation on the 4-bit error counter copy
    pulse_start(0, 0, 0);
    RX_DATA = 32'h0; RX_VALID = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", s_err_cnt, 4'd14);
    for (int i = 0; i < 6; i++) tick();
    RX_VALID = 1'b0;
    check("sat_hold", s_err_cnt, 4'hF);
    check("sat_flag", s_err_flag, 1'b1);
    check("sat_wide_cnt", ERR_CNT, 20);

    // Reset in the middle of the second gap
    pulse_start(8, 4, 3);
    for (int c = 0; c < 20; c++) tick();
    check("pre_reset_gap", {GEN_TRIG, BUSY, BURST_IDX}, {2'b11, 8'd1});
    RST_N = 1'b0;
    tick();
    check("rst_gap_outputs", {GEN_TRIG, BUSY, DONE, BURST_IDX, ERR_FLAG}, {1'b1, 1'b0, 1'b0, 8'd0, 1'b0});
    check("rst_gap_err_cnt", ERR_CNT, 0);
    RST_N = 1'b1;
    tick(); tick();
    check("post_reset_idle", {GEN_TRIG, BUSY, DONE}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
